port_wr_frontend: RTL and testbench
===================================

Name: port_wr_frontend

Overview:
Ingress-side port frontend, the write-direction counterpart of the port read frontend. Accepts packets from the external write interface (wr_sop / wr_vld / wr_data / wr_eop) and buffers them in a local word FIFO. It publishes only complete packets to the internal transfer interface (xfer_data_vld / xfer_data / end_of_packet) under downstream ready. It also extracts header fields for the scheduler and drops packets that overflow the FIFO.

Parameters:
DATA_WIDTH, 16, width of wr_data / xfer_data
DEPTH, 64, FIFO depth in words; power of two, at least 4
PTR_W, $clog2(DEPTH)+1, pointer width including wrap bit (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_sop  in  1  one-cycle pulse marking packet start; carries no data
wr_vld  in  1  data word valid
wr_data  in  DATA_WIDTH  packet word; first word of a packet is the header
wr_eop  in  1  one-cycle pulse after the last data word; carries no data
xfer_ready  in  1  downstream accepts a word this cycle
xfer_data_vld  out  1  xfer_data valid
xfer_data  out  DATA_WIDTH  buffered packet word
end_of_packet  out  1  qualifies the last word of a packet, valid only with xfer_data_vld
pkt_vld  out  1  one-cycle pulse: a packet was committed
pkt_dest  out  4  header[3:0] of the committed packet
pkt_prior  out  3  header[6:4] of the committed packet
pkt_words  out  PTR_W  word count of the committed packet, header included
pkt_drop  out  1  one-cycle pulse: a packet was discarded
fifo_free  out  PTR_W  DEPTH minus words written but not yet read

Behaviour:
- Reset: every output is 0 and fifo_free is DEPTH. All pointers are 0, the FSM is IDLE, and the eop flag array is cleared. A reset mid-packet discards all buffered and committed data.
- Pointers: wr_ptr (working), cm_ptr (committed), rd_ptr; each PTR_W bits wide, wrapping modulo 2*DEPTH. pkt_base holds wr_ptr at sop. used = wr_ptr - rd_ptr; full when used == DEPTH.
- Write FSM:
  - IDLE: wr_sop -> HDR and pkt_base <= wr_ptr. wr_vld and wr_eop are ignored.
  - HDR: the first wr_vld word is written, header fields are latched, state -> BODY. wr_eop with no data -> IDLE, no commit, no drop pulse.
  - BODY: each wr_vld writes one word and wr_ptr++.
  - wr_eop in BODY: set eop_flag[wr_ptr-1], cm_ptr <= wr_ptr, pulse pkt_vld with latched fields and pkt_words = wr_ptr - pkt_base, state -> IDLE.
  - Overflow: wr_vld while full in HDR or BODY -> state DROP and wr_ptr <= pkt_base (rollback).
  - DROP: wr_vld is ignored. wr_eop pulses pkt_drop and returns to IDLE.
  - wr_sop in HDR/BODY/DROP: the current packet is aborted (wr_ptr <= pkt_base, pkt_drop pulses) and a new packet starts (pkt_base = rolled-back pointer, state HDR).
- Read side:
  - A read fires at a clock edge when xfer_ready && rd_ptr != cm_ptr.
  - On that edge: xfer_data <= mem[rd_ptr], end_of_packet <= eop_flag[rd_ptr], xfer_data_vld <= 1, eop_flag[rd_ptr] cleared, rd_ptr++.
  - Otherwise xfer_data_vld <= 0 and end_of_packet <= 0.
  - Output is registered: one cycle from accepted ready to data.
- Latency: wr_eop sampled at edge T; cm_ptr is updated at T. With xfer_ready high, the first word is output after edge T+1.
- Uncommitted words are never read. Writes and reads proceed in the same cycle. Commit and read in the same cycle are legal.
- fifo_free = DEPTH - used, registered, and reflects rollback on the cycle after it.
- Width rule: all pointer arithmetic is modulo 2^PTR_W. Only the low PTR_W-1 bits index mem.

Decomposition:
- Shared package: header field offsets (DEST_LSB=0, DEST_W=4, PRIOR_LSB=4, PRIOR_W=3) and the write FSM state enum (IDLE, HDR, BODY, DROP). Both are reused by the read frontend and the scheduler.
- One natural sub-module, wr_pkt_fifo: the dual-pointer word RAM plus eop flag array, with write/commit/rollback/read ports. The FSM and header latch stay in port_wr_frontend.

Test Plan:
- Single packet: sop; words 0x0135, 0xAAAA, 0xBBBB, 0xCCCC; eop; xfer_ready=1 -> pkt_vld with dest=5, prior=3, words=4. Four xfer words appear in order starting 2 cycles after eop; end_of_packet is high only with 0xCCCC; fifo_free returns to 64.
- Backpressure: same packet with xfer_ready toggling 1,0,1,0 -> one word per ready-high cycle, no duplicates or skips, end_of_packet only on the fourth word.
- Overflow (DEPTH=8): 10-word packet -> pkt_drop at eop, no pkt_vld, no xfer output, fifo_free=8. A following 3-word packet is delivered intact.
- Abort: sop, 2 words, sop, 3 words, eop -> one pkt_drop at the second sop, one pkt_vld with words=3, only the 3 new words delivered.
- Empty packet and stray input: sop then eop, then wr_vld in IDLE -> no pkt_vld, no pkt_drop, no FIFO writes.
- Reset mid-stream: reset asserted while a packet is committed and half read -> all outputs 0, fifo_free=64, and nothing is emitted afterwards until a new packet commits.

Source files
------------

// File: rtl/port_wr_frontend_pkg.sv
// Shared definitions for the port frontends and the scheduler.
// - Header field offsets: where destination and priority sit in the first packet word.
// - Write FSM state encoding.
package port_wr_frontend_pkg;

    localparam int unsigned DEST_LSB  = 0;
    localparam int unsigned DEST_W    = 4;
    localparam int unsigned PRIOR_LSB = 4;
    localparam int unsigned PRIOR_W   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StBody,
        StDrop
    } wr_state_e;

endpackage

// File: rtl/wr_pkt_fifo.sv
// Packet word FIFO with a working write pointer, a committed pointer and a read pointer.
// Words between cm_ptr and wr_ptr belong to the packet still being written. The reader
// never sees them, and a rollback discards them. A per-word eop flag marks packet ends.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr_en_i, wr_data_i    write one word at wr_ptr and advance wr_ptr
//   commit_i              flag wr_ptr-1 as end of packet and publish up to wr_ptr
//   rollback_i/_ptr_i     move wr_ptr back to the packet base
//   rd_ready_i            downstream ready; a read fires when committed data exists
//   wr_ptr_o, full_o      write-side status
//   rd_vld_o/data_o/eop_o registered read output
//   free_o                registered Depth - (wr_ptr - rd_ptr)
module wr_pkt_fifo #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Depth     = 64,
    parameter int unsigned PtrW      = $clog2(Depth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 commit_i,
    input  logic                 rollback_i,
    input  logic [PtrW-1:0]      rollback_ptr_i,
    input  logic                 rd_ready_i,
    output logic [PtrW-1:0]      wr_ptr_o,
    output logic                 full_o,
    output logic                 rd_vld_o,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 rd_eop_o,
    output logic [PtrW-1:0]      free_o
);

    localparam int unsigned AddrW = PtrW - 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [Depth-1:0]     eop_q;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      cm_ptr_q, cm_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      last_ptr;
    logic [PtrW-1:0]      free_d;
    logic                 rd_fire;

    assign full_o   = (wr_ptr_q - rd_ptr_q) == PtrW'(Depth);
    assign rd_fire  = rd_ready_i && (rd_ptr_q != cm_ptr_q);
    assign last_ptr = wr_ptr_q - PtrW'(1);
    assign wr_ptr_o = wr_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (rollback_i) begin
            wr_ptr_d = rollback_ptr_i;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        cm_ptr_d = commit_i ? wr_ptr_q : cm_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        // Computed from next-state pointers so free_o tracks the pointers it describes.
        free_d   = PtrW'(Depth) - (wr_ptr_d - rd_ptr_d);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            cm_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            eop_q     <= '0;
            rd_vld_o  <= 1'b0;
            rd_data_o <= '0;
            rd_eop_o  <= 1'b0;
            free_o    <= PtrW'(Depth);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            free_o   <= free_d;
            // Set and clear never hit the same slot: the set targets an uncommitted word.
            if (rd_fire) begin
                eop_q[rd_ptr_q[AddrW-1:0]] <= 1'b0;
            end
            if (commit_i) begin
                eop_q[last_ptr[AddrW-1:0]] <= 1'b1;
            end
            if (rd_fire) begin
                rd_vld_o  <= 1'b1;
                rd_data_o <= mem_q[rd_ptr_q[AddrW-1:0]];
                rd_eop_o  <= eop_q[rd_ptr_q[AddrW-1:0]];
            end else begin
                rd_vld_o <= 1'b0;
                rd_eop_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/port_wr_frontend.sv
// Ingress port frontend. It buffers packets from the write interface, and the transfer
// interface sees a packet only after its wr_eop commits it. Header fields go to the
// scheduler. Packets that overflow the FIFO or are cut short by a new wr_sop are dropped.
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   wr_sop, wr_vld, wr_data, wr_eop            external write interface
//   xfer_ready, xfer_data_vld, xfer_data,
//   end_of_packet                              internal transfer interface
//   pkt_vld, pkt_dest, pkt_prior, pkt_words    commit pulse with header fields and length
//   pkt_drop                                   discard pulse
//   fifo_free                                  free FIFO words, uncommitted ones counted as used
module port_wr_frontend #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned PTR_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_sop,
    input  logic                  wr_vld,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_eop,
    input  logic                  xfer_ready,
    output logic                  xfer_data_vld,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  end_of_packet,
    output logic                  pkt_vld,
    output logic [3:0]            pkt_dest,
    output logic [2:0]            pkt_prior,
    output logic [PTR_W-1:0]      pkt_words,
    output logic                  pkt_drop,
    output logic [PTR_W-1:0]      fifo_free
);

    import port_wr_frontend_pkg::*;

    wr_state_e          state_q;
    logic [PTR_W-1:0]   base_q;
    logic [DEST_W-1:0]  dest_q;
    logic [PRIOR_W-1:0] prior_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic               full;
    logic               wr_en;
    logic               commit;
    logic               rollback;

    // A new sop outranks everything. Otherwise eop outranks a word in the same cycle.
    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        if (wr_sop) begin
            rollback = (state_q != StIdle);
        end else begin
            case (state_q)
                StHdr, StBody: begin
                    if (wr_eop) begin
                        commit = (state_q == StBody);
                    end else if (wr_vld) begin
                        rollback = full;
                        wr_en    = !full;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            base_q    <= '0;
            dest_q    <= '0;
            prior_q   <= '0;
            pkt_vld   <= 1'b0;
            pkt_dest  <= '0;
            pkt_prior <= '0;
            pkt_words <= '0;
            pkt_drop  <= 1'b0;
        end else begin
            pkt_vld  <= 1'b0;
            pkt_drop <= 1'b0;
            if (wr_sop) begin
                // On abort the rolled-back pointer equals base_q, so the base stays put.
                if (state_q == StIdle) begin
                    base_q <= wr_ptr;
                end else begin
                    pkt_drop <= 1'b1;
                end
                state_q <= StHdr;
            end else begin
                case (state_q)
                    StHdr: begin
                        if (wr_eop) begin
                            state_q <= StIdle;
                        end else if (rollback) begin
                            state_q <= StDrop;
                        end else if (wr_en) begin
                            dest_q  <= wr_data[DEST_LSB +: DEST_W];
                            prior_q <= wr_data[PRIOR_LSB +: PRIOR_W];
                            state_q <= StBody;
                        end
                    end
                    StBody: begin
                        if (commit) begin
                            pkt_vld   <= 1'b1;
                            pkt_dest  <= dest_q;
                            pkt_prior <= prior_q;
                            pkt_words <= wr_ptr - base_q;
                            state_q   <= StIdle;
                        end else if (rollback) begin
                            state_q <= StDrop;
                        end
                    end
                    StDrop: begin
                        if (wr_eop) begin
                            pkt_drop <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    wr_pkt_fifo #(
        .DataWidth (DATA_WIDTH),
        .Depth     (DEPTH),
        .PtrW      (PTR_W)
    ) u_fifo (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .commit_i       (commit),
        .rollback_i     (rollback),
        .rollback_ptr_i (base_q),
        .rd_ready_i     (xfer_ready),
        .wr_ptr_o       (wr_ptr),
        .full_o         (full),
        .rd_vld_o       (xfer_data_vld),
        .rd_data_o      (xfer_data),
        .rd_eop_o       (end_of_packet),
        .free_o         (fifo_free)
    );

endmodule

// File: tb/tb_port_wr_frontend.sv
module tb_port_wr_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_sop, wr_vld, wr_eop, xfer_ready;
    logic [15:0] wr_data;
    logic        xfer_data_vld, end_of_packet, pkt_vld, pkt_drop;
    logic [15:0] xfer_data;
    logic [3:0]  pkt_dest;
    logic [2:0]  pkt_prior;
    logic [6:0]  pkt_words, fifo_free;

    int vectors = 0;
    int miscompares = 0;
    int xfer_cnt = 0, vld_cnt = 0, drop_cnt = 0;
    logic [3:0]  last_dest;
    logic [2:0]  last_prior;
    logic [6:0]  last_words;
    logic [16:0] exp_q[$];
    logic [15:0] tx_q[$];

    port_wr_frontend dut (
        .clk           (clk),
        .rst           (rst),
        .wr_sop        (wr_sop),
        .wr_vld        (wr_vld),
        .wr_data       (wr_data),
        .wr_eop        (wr_eop),
        .xfer_ready    (xfer_ready),
        .xfer_data_vld (xfer_data_vld),
        .xfer_data     (xfer_data),
        .end_of_packet (end_of_packet),
        .pkt_vld       (pkt_vld),
        .pkt_dest      (pkt_dest),
        .pkt_prior     (pkt_prior),
        .pkt_words     (pkt_words),
        .pkt_drop      (pkt_drop),
        .fifo_free     (fifo_free)
    );

    always #5 clk = ~clk;

    // Scoreboard: every transfer word is checked against the queue in order.
    always @(negedge clk) begin
        logic [16:0] exp;
        if (pkt_vld) begin
            vld_cnt++;
            last_dest  = pkt_dest;
            last_prior = pkt_prior;
            last_words = pkt_words;
        end
        if (pkt_drop) drop_cnt++;
        if (xfer_data_vld) begin
            xfer_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL xfer_unexpected: got %h eop=%b, required no output",
                         xfer_data, end_of_packet);
            end else begin
                exp = exp_q.pop_front();
                if ({xfer_data, end_of_packet} !== exp) begin
                    miscompares++;
                    $display("FAIL xfer_word: got %h eop=%b, required %h eop=%b",
                             xfer_data, end_of_packet, exp[16:1], exp[0]);
                end
            end
        end else if (end_of_packet !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL eop_without_vld: got %b, required 0", end_of_packet);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sop;
        wr_sop = 1'b1;
        tick();
        wr_sop = 1'b0;
    endtask

    task automatic drive_words(input bit push_exp);
        foreach (tx_q[i]) begin
            wr_vld  = 1'b1;
            wr_data = tx_q[i];
            if (push_exp) exp_q.push_back({tx_q[i], i == tx_q.size() - 1});
            tick();
        end
        wr_vld = 1'b0;
    endtask

    task automatic drive_eop;
        wr_eop = 1'b1;
        tick();
        wr_eop = 1'b0;
    endtask

    task automatic send_pkt(input bit push_exp);
        drive_sop();
        drive_words(push_exp);
        drive_eop();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d words pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset;
        vectors++;
        if ({xfer_data_vld, end_of_packet, pkt_vld, pkt_drop} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b, required 0000",
                     {xfer_data_vld, end_of_packet, pkt_vld, pkt_drop});
        end
        vectors++;
        if ({xfer_data, pkt_dest, pkt_prior, pkt_words} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields: got %h/%h/%h/%h, required 0", xfer_data, pkt_dest,
                     pkt_prior, pkt_words);
        end
        vectors++;
        if (fifo_free !== 7'd64) begin
            miscompares++;
            $display("FAIL reset_free: got %0d, required 64", fifo_free);
        end
    endtask

    task automatic test_single;
        int v0 = vld_cnt, d0 = drop_cnt;
        xfer_ready = 1'b1;
        tx_q = '{16'h0135, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_pkt(1'b1);
        vectors++;
        if (xfer_data_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: vld got %b, required 0", xfer_data_vld);
        end
        tick();
        vectors++;
        if (xfer_data_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_first: vld got %b, required 1", xfer_data_vld);
        end
        wait_drain("single");
        vectors++;
        if (vld_cnt - v0 != 1 || drop_cnt != d0) begin
            miscompares++;
            $display("FAIL single_pulses: vld %0d drop %0d, required 1 0", vld_cnt - v0,
                     drop_cnt - d0);
        end
        vectors++;
        if ({last_dest, last_prior, last_words} !== {4'd5, 3'd3, 7'd4}) begin
            miscompares++;
            $display("FAIL single_fields: dest %0d prior %0d words %0d, required 5 3 4",
                     last_dest, last_prior, last_words);
        end
        vectors++;
        if (fifo_free !== 7'd64) begin
            miscompares++;
            $display("FAIL single_free: got %0d, required 64", fifo_free);
        end
    endtask

    task automatic test_backpressure;
        int x0;
        xfer_ready = 1'b0;
        tx_q = '{16'h0135, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_pkt(1'b1);
        x0 = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            xfer_ready = (i % 2 == 0) && (i < 8);
            tick();
        end
        tick();
        vectors++;
        if (xfer_cnt - x0 != 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words, required 4", xfer_cnt - x0);
        end
        wait_drain("bp");
    endtask

    task automatic test_overflow;
        int v0 = vld_cnt, d0 = drop_cnt, x0 = xfer_cnt;
        xfer_ready = 1'b1;
        drive_sop();
        for (int i = 0; i < 66; i++) begin
            wr_vld  = 1'b1;
            wr_data = 16'h1000 + 16'(i);
            tick();
            if (i == 63) begin
                wr_vld = 1'b0;
                tick();
                vectors++;
                if (fifo_free !== 7'd0) begin
                    miscompares++;
                    $display("FAIL ovf_full_free: got %0d, required 0", fifo_free);
                end
            end
        end
        wr_vld = 1'b0;
        drive_eop();
        repeat (4) tick();
        vectors++;
        if (drop_cnt - d0 != 1 || vld_cnt != v0 || xfer_cnt != x0) begin
            miscompares++;
            $display("FAIL ovf_pulses: drop %0d vld %0d xfer %0d, required 1 0 0",
                     drop_cnt - d0, vld_cnt - v0, xfer_cnt - x0);
        end
        vectors++;
        if (fifo_free !== 7'd64) begin
            miscompares++;
            $display("FAIL ovf_free: got %0d, required 64", fifo_free);
        end
        tx_q = '{16'h0072, 16'h5555, 16'h6666};
        send_pkt(1'b1);
        wait_drain("ovf_next");
        vectors++;
        if (vld_cnt - v0 != 1 || last_words !== 7'd3 || last_dest !== 4'd2 ||
            last_prior !== 3'd7) begin
            miscompares++;
            $display("FAIL ovf_next: vld %0d words %0d dest %0d prior %0d, required 1 3 2 7",
                     vld_cnt - v0, last_words, last_dest, last_prior);
        end
    endtask

    task automatic test_abort;
        int v0 = vld_cnt, d0 = drop_cnt;
        xfer_ready = 1'b1;
        drive_sop();
        tx_q = '{16'h00FF, 16'hDEAD};
        drive_words(1'b0);
        drive_sop();
        tx_q = '{16'h0049, 16'h1234, 16'h5678};
        drive_words(1'b1);
        drive_eop();
        wait_drain("abort");
        vectors++;
        if (drop_cnt - d0 != 1 || vld_cnt - v0 != 1) begin
            miscompares++;
            $display("FAIL abort_pulses: drop %0d vld %0d, required 1 1", drop_cnt - d0,
                     vld_cnt - v0);
        end
        vectors++;
        if ({last_dest, last_prior, last_words} !== {4'd9, 3'd4, 7'd3}) begin
            miscompares++;
            $display("FAIL abort_fields: dest %0d prior %0d words %0d, required 9 4 3",
                     last_dest, last_prior, last_words);
        end
    endtask

    task automatic test_empty;
        int v0 = vld_cnt, d0 = drop_cnt, x0 = xfer_cnt;
        xfer_ready = 1'b1;
        drive_sop();
        drive_eop();
        tx_q = '{16'h0011, 16'h0022};
        drive_words(1'b0);
        repeat (4) tick();
        vectors++;
        if (vld_cnt != v0 || drop_cnt != d0 || xfer_cnt != x0) begin
            miscompares++;
            $display("FAIL empty_pulses: vld %0d drop %0d xfer %0d, required 0 0 0",
                     vld_cnt - v0, drop_cnt - d0, xfer_cnt - x0);
        end
        vectors++;
        if (fifo_free !== 7'd64) begin
            miscompares++;
            $display("FAIL empty_free: got %0d, required 64", fifo_free);
        end
    endtask

    task automatic test_reset_mid;
        int x0, n;
        xfer_ready = 1'b0;
        tx_q = '{16'h0023, 16'h7777, 16'h8888, 16'h9999};
        send_pkt(1'b1);
        x0 = xfer_cnt;
        xfer_ready = 1'b1;
        n = 0;
        while (xfer_cnt - x0 < 2 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (xfer_cnt - x0 < 2) begin
            miscompares++;
            $display("FAIL rstmid_start: got %0d words, required 2", xfer_cnt - x0);
        end
        rst = 1'b1;
        tick();
        exp_q.delete();
        vectors++;
        if ({xfer_data_vld, end_of_packet, pkt_vld, pkt_drop} !== 4'b0 || xfer_data !== '0 ||
            fifo_free !== 7'd64) begin
            miscompares++;
            $display("FAIL rstmid_outputs: strobes %b data %h free %0d, required 0 0 64",
                     {xfer_data_vld, end_of_packet, pkt_vld, pkt_drop}, xfer_data, fifo_free);
        end
        rst = 1'b0;
        x0 = xfer_cnt;
        repeat (10) tick();
        vectors++;
        if (xfer_cnt != x0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: got %0d words, required 0", xfer_cnt - x0);
        end
        tx_q = '{16'h0014, 16'hABCD};
        send_pkt(1'b1);
        wait_drain("rstmid_new");
    endtask

    initial begin
        rst = 1'b1;
        wr_sop = 1'b0;
        wr_vld = 1'b0;
        wr_eop = 1'b0;
        wr_data = '0;
        xfer_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single();
        test_backpressure();
        test_overflow();
        test_abort();
        test_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
